// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-lane register file: clear-engine state
// encodings and default geometry.
package regfile_mp_pkg;

    // Clear-engine states
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    // Default geometry
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_LANES  = 2;

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by reserves, cleared by
// writes or by the bulk-clear engine, and looked up for every read port.
module regfile_mp_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LANES  = DEF_LANES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush_en,
    input  logic [ADDR_W-1:0]       flush_ptr,
    input  logic [LANES-1:0]        rsv_en,
    input  logic [LANES*ADDR_W-1:0] rsv_addr,
    input  logic [LANES-1:0]        wr_act,
    input  logic [LANES*ADDR_W-1:0] wr_addr,
    input  logic [LANES*ADDR_W-1:0] rs1,
    input  logic [LANES*ADDR_W-1:0] rs2,
    output logic [LANES-1:0]        busy1,
    output logic [LANES-1:0]        busy2
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;
    logic [DEPTH-1:0] set_mask;
    logic [DEPTH-1:0] clr_mask;

    // Next pending state: clears from writes and the flush, then sets on top so a new producer wins
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        set_mask = '0;
        clr_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            if (wr_act[i]) begin
                clr_mask[wr_addr[i*ADDR_W +: ADDR_W]] = 1'b1;
            end
            if (rsv_en[i] && !flush_en && (rsv_addr[i*ADDR_W +: ADDR_W] != '0)) begin
                set_mask[rsv_addr[i*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
        if (flush_en) begin
            clr_mask[flush_ptr] = 1'b1;
        end
        pend_d = (pend_q & ~clr_mask) | set_mask;
    end

    // Pending bits register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops sample together.
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Busy lookup: masked by a same-cycle write, zero for r0, all-ones while flushing
    always_comb begin
        busy1 = '0;
        busy2 = '0;
        for (int i = 0; i < LANES; i++) begin
            busy1[i] = pend_q[rs1[i*ADDR_W +: ADDR_W]];
            busy2[i] = pend_q[rs2[i*ADDR_W +: ADDR_W]];
            for (int l = 0; l < LANES; l++) begin
                if (wr_act[l] && (wr_addr[l*ADDR_W +: ADDR_W] == rs1[i*ADDR_W +: ADDR_W])) begin
                    busy1[i] = 1'b0;
                end
                if (wr_act[l] && (wr_addr[l*ADDR_W +: ADDR_W] == rs2[i*ADDR_W +: ADDR_W])) begin
                    busy2[i] = 1'b0;
                end
            end
            if (rs1[i*ADDR_W +: ADDR_W] == '0) begin
                busy1[i] = 1'b0;
            end
            if (rs2[i*ADDR_W +: ADDR_W] == '0) begin
                busy2[i] = 1'b0;
            end
            if (flush_en) begin
                busy1[i] = 1'b1;
                busy2[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-lane register file: 2 reads + 1 write + 1 reserve per lane, write-through
// bypass, highest-lane write priority, optional registered reads, pending-write
// scoreboard and a sequenced bulk-clear engine.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int LANES    = DEF_LANES,
    parameter int READ_REG = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [LANES*ADDR_W-1:0] rs1,
    input  logic [LANES*ADDR_W-1:0] rs2,
    output logic [LANES*DATA_W-1:0] rdata1,
    output logic [LANES*DATA_W-1:0] rdata2,
    input  logic [LANES-1:0]        we,
    input  logic [LANES*ADDR_W-1:0] rd,
    input  logic [LANES*DATA_W-1:0] wdata,
    input  logic [LANES-1:0]        rsv_en,
    input  logic [LANES*ADDR_W-1:0] rsv_addr,
    output logic [LANES-1:0]        busy1,
    output logic [LANES-1:0]        busy2,
    input  logic                    clear_req,
    output logic                    clear_busy
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = '1;

    logic [DATA_W-1:0]       mem_q [DEPTH];
    logic [0:0]              state_q;
    logic [0:0]              state_d;
    logic [ADDR_W-1:0]       ptr_q;
    logic [ADDR_W-1:0]       ptr_d;
    logic                    clearing;
    logic [LANES-1:0]        wr_act;
    logic [LANES*DATA_W-1:0] rd1_val;
    logic [LANES*DATA_W-1:0] rd2_val;

    assign clearing   = (state_q == ST_CLEAR);
    assign clear_busy = clearing;

    // Qualify lane writes: nonzero destination and no clear in progress
    always_comb begin
        wr_act = '0;
        for (int i = 0; i < LANES; i++) begin
            wr_act[i] = we[i] && (rd[i*ADDR_W +: ADDR_W] != '0) && !clearing;
        end
    end

    // Clear engine next state: walk ptr from 1 to the last entry
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    ptr_d   = ADDR_W'(1);
                end
            end
            ST_CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Clear engine registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Storage update: reset, then clear sweep, then lane writes in ascending lane order
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: storage is a flop array so a synchronous reset can zero every entry at once.
            for (int j = 0; j < DEPTH; j++) begin
                mem_q[j] <= '0;
            end
        end else if (clearing) begin
            mem_q[ptr_q] <= '0;
        end else begin
            // NOTE: a later lane's non-blocking write to the same address overrides an earlier one, so the highest lane wins.
            for (int i = 0; i < LANES; i++) begin
                if (wr_act[i]) begin
                    mem_q[rd[i*ADDR_W +: ADDR_W]] <= wdata[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Read ports with write-through bypass; zero for r0, during reset and during a clear
    always_comb begin
        rd1_val = '0;
        rd2_val = '0;
        for (int i = 0; i < LANES; i++) begin
            rd1_val[i*DATA_W +: DATA_W] = mem_q[rs1[i*ADDR_W +: ADDR_W]];
            rd2_val[i*DATA_W +: DATA_W] = mem_q[rs2[i*ADDR_W +: ADDR_W]];
            for (int l = 0; l < LANES; l++) begin
                if (wr_act[l] && (rd[l*ADDR_W +: ADDR_W] == rs1[i*ADDR_W +: ADDR_W])) begin
                    rd1_val[i*DATA_W +: DATA_W] = wdata[l*DATA_W +: DATA_W];
                end
                if (wr_act[l] && (rd[l*ADDR_W +: ADDR_W] == rs2[i*ADDR_W +: ADDR_W])) begin
                    rd2_val[i*DATA_W +: DATA_W] = wdata[l*DATA_W +: DATA_W];
                end
            end
            if (reset || clearing || (rs1[i*ADDR_W +: ADDR_W] == '0)) begin
                rd1_val[i*DATA_W +: DATA_W] = '0;
            end
            if (reset || clearing || (rs2[i*ADDR_W +: ADDR_W] == '0)) begin
                rd2_val[i*DATA_W +: DATA_W] = '0;
            end
        end
    end

    if (READ_REG != 0) begin : g_reg_rd
        logic [LANES*DATA_W-1:0] rdata1_q;
        logic [LANES*DATA_W-1:0] rdata2_q;

        // Registered read data, one cycle behind the address
        always_ff @(posedge clk) begin
            if (reset) begin
                rdata1_q <= '0;
                rdata2_q <= '0;
            end else begin
                rdata1_q <= rd1_val;
                rdata2_q <= rd2_val;
            end
        end

        assign rdata1 = rdata1_q;
        assign rdata2 = rdata2_q;
    end else begin : g_comb_rd
        assign rdata1 = rd1_val;
        assign rdata2 = rd2_val;
    end

    regfile_mp_scoreboard #(
        .ADDR_W (ADDR_W),
        .LANES  (LANES)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .flush_en  (clearing),
        .flush_ptr (ptr_q),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .wr_act    (wr_act),
        .wr_addr   (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .busy1     (busy1),
        .busy2     (busy2)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: one combinational-read and one
// registered-read instance share stimulus and are compared against an
// array-based reference model, plus a directed vector table and clear/reset sequences.
module tb_regfile_mp;

    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int LN    = 2;
    localparam int DEPTH = 32;

    logic          clk;
    logic          reset;
    logic [9:0]    rs1, rs2, rd, rsv_addr;
    logic [15:0]   wdata;
    logic [1:0]    we, rsv_en;
    logic          clear_req;
    logic [15:0]   rdata1, rdata2, rdata1_r, rdata2_r;
    logic [1:0]    busy1, busy2, busy1_r, busy2_r;
    logic          clear_busy, clear_busy_r;

    int checks;
    int errors;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .LANES(LN), .READ_REG(0)) dut (
        .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2),
        .rdata1(rdata1), .rdata2(rdata2), .we(we), .rd(rd), .wdata(wdata),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy1(busy1), .busy2(busy2),
        .clear_req(clear_req), .clear_busy(clear_busy)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .LANES(LN), .READ_REG(1)) dut_r (
        .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2),
        .rdata1(rdata1_r), .rdata2(rdata2_r), .we(we), .rd(rd), .wdata(wdata),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy1(busy1_r), .busy2(busy2_r),
        .clear_req(clear_req), .clear_busy(clear_busy_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0]  mem_m  [DEPTH];
    logic        pend_m [DEPTH];
    int          clr_cnt;          // clear cycles still to run
    logic [15:0] nxt_r1, nxt_r2, exp_r1, exp_r2;
    bit          r_valid;

    function automatic logic [4:0] lane_addr(input logic [9:0] v, input int l);
        return v[l*AW +: AW];
    endfunction

    function automatic bit wr_active(input int l);
        return we[l] && (lane_addr(rd, l) != 5'd0) && (clr_cnt == 0);
    endfunction

    function automatic logic [7:0] exp_read(input logic [4:0] a);
        logic [7:0] v;
        if (reset || clr_cnt != 0 || a == 5'd0) return 8'h00;
        v = mem_m[a];
        for (int l = 0; l < LN; l++)
            if (wr_active(l) && lane_addr(rd, l) == a) v = wdata[l*DW +: DW];
        return v;
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (clr_cnt != 0) return 1'b1;
        if (a == 5'd0) return 1'b0;
        for (int l = 0; l < LN; l++)
            if (wr_active(l) && lane_addr(rd, l) == a) return 1'b0;
        return pend_m[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_check();
        logic [15:0] e1, e2;
        logic [1:0]  b1, b2;
        for (int l = 0; l < LN; l++) begin
            e1[l*DW +: DW] = exp_read(lane_addr(rs1, l));
            e2[l*DW +: DW] = exp_read(lane_addr(rs2, l));
            b1[l] = exp_busy(lane_addr(rs1, l));
            b2[l] = exp_busy(lane_addr(rs2, l));
        end
        check("model rdata1", 32'(rdata1), 32'(e1));
        check("model rdata2", 32'(rdata2), 32'(e2));
        check("model busy1", 32'(busy1), 32'(b1));
        check("model busy2", 32'(busy2), 32'(b2));
        check("model clear_busy", 32'(clear_busy), 32'(clr_cnt != 0));
        check("model busy1 regrd", 32'(busy1_r), 32'(b1));
        check("model busy2 regrd", 32'(busy2_r), 32'(b2));
        check("model clear_busy regrd", 32'(clear_busy_r), 32'(clr_cnt != 0));
        if (r_valid) begin
            check("model rdata1 regrd", 32'(rdata1_r), 32'(exp_r1));
            check("model rdata2 regrd", 32'(rdata2_r), 32'(exp_r2));
        end
        nxt_r1 = e1;
        nxt_r2 = e2;
    endtask

    task automatic model_edge();
        exp_r1  = nxt_r1;
        exp_r2  = nxt_r2;
        r_valid = 1'b1;
        if (reset) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem_m[a]  = 8'h00;
                pend_m[a] = 1'b0;
            end
            clr_cnt = 0;
        end else if (clr_cnt != 0) begin
            mem_m[DEPTH - clr_cnt]  = 8'h00;
            pend_m[DEPTH - clr_cnt] = 1'b0;
            clr_cnt--;
        end else begin
            for (int l = 0; l < LN; l++) begin
                if (wr_active(l)) begin
                    mem_m[lane_addr(rd, l)]  = wdata[l*DW +: DW];
                    pend_m[lane_addr(rd, l)] = 1'b0;
                end
            end
            for (int l = 0; l < LN; l++)
                if (rsv_en[l] && lane_addr(rsv_addr, l) != 5'd0) pend_m[lane_addr(rsv_addr, l)] = 1'b1;
            if (clear_req) clr_cnt = DEPTH - 1;
        end
    endtask

    // ---------------- cycle helpers ----------------
    task automatic drive_idle();
        we = '0; rd = '0; wdata = '0; rsv_en = '0; rsv_addr = '0;
        rs1 = '0; rs2 = '0; clear_req = 1'b0;
    endtask

    task automatic settle();
        #2;
        model_check();
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic [1:0]  we;
        logic [9:0]  rd;
        logic [15:0] wdata;
        logic [1:0]  rsv;
        logic [9:0]  ra;
        logic [9:0]  rs1;
        logic [9:0]  rs2;
        logic [15:0] e1;
        logic [15:0] e2;
        logic [1:0]  eb1;
        logic [1:0]  eb2;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bit done;

        checks = 0; errors = 0;
        for (int a = 0; a < DEPTH; a++) begin
            mem_m[a] = 8'h00; pend_m[a] = 1'b0;
        end
        clr_cnt = 0; r_valid = 1'b0; nxt_r1 = '0; nxt_r2 = '0; exp_r1 = '0; exp_r2 = '0;

        //            we     rd               wdata            rsv    ra               rs1              rs2              e1               e2               eb1    eb2
        vecs[0]  = '{2'b00, {5'd0, 5'd0},  {8'h00, 8'h00}, 2'b00, {5'd0, 5'd0},  {5'd3, 5'd3},  {5'd7, 5'd0},  {8'h00, 8'h00}, {8'h00, 8'h00}, 2'b00, 2'b00};
        vecs[1]  = '{2'b01, {5'd0, 5'd3},  {8'h00, 8'h5A}, 2'b00, {5'd0, 5'd0},  {5'd3, 5'd3},  {5'd0, 5'd0},  {8'h5A, 8'h5A}, {8'h00, 8'h00}, 2'b00, 2'b00};
        vecs[2]  = '{2'b00, {5'd0, 5'd0},  {8'h00, 8'h00}, 2'b00, {5'd0, 5'd0},  {5'd3, 5'd0},  {5'd0, 5'd3},  {8'h5A, 8'h00}, {8'h00, 8'h5A}, 2'b00, 2'b00};
        vecs[3]  = '{2'b11, {5'd7, 5'd7},  {8'h22, 8'h11}, 2'b00, {5'd0, 5'd0},  {5'd0, 5'd7},  {5'd7, 5'd3},  {8'h00, 8'h22}, {8'h22, 8'h5A}, 2'b00, 2'b00};
        vecs[4]  = '{2'b00, {5'd0, 5'd0},  {8'h00, 8'h00}, 2'b00, {5'd0, 5'd0},  {5'd7, 5'd7},  {5'd3, 5'd7},  {8'h22, 8'h22}, {8'h5A, 8'h22}, 2'b00, 2'b00};
        vecs[5]  = '{2'b01, {5'd0, 5'd0},  {8'h00, 8'hFF}, 2'b01, {5'd0, 5'd0},  {5'd0, 5'd0},  {5'd0, 5'd0},  {8'h00, 8'h00}, {8'h00, 8'h00}, 2'b00, 2'b00};
        vecs[6]  = '{2'b00, {5'd0, 5'd0},  {8'h00, 8'h00}, 2'b01, {5'd0, 5'd4},  {5'd4, 5'd0},  {5'd0, 5'd0},  {8'h00, 8'h00}, {8'h00, 8'h00}, 2'b00, 2'b00};
        vecs[7]  = '{2'b00, {5'd0, 5'd0},  {8'h00, 8'h00}, 2'b00, {5'd0, 5'd0},  {5'd0, 5'd4},  {5'd4, 5'd0},  {8'h00, 8'h00}, {8'h00, 8'h00}, 2'b01, 2'b10};
        vecs[8]  = '{2'b10, {5'd4, 5'd0},  {8'h33, 8'h00}, 2'b00, {5'd0, 5'd0},  {5'd0, 5'd4},  {5'd4, 5'd0},  {8'h00, 8'h33}, {8'h33, 8'h00}, 2'b00, 2'b00};
        vecs[9]  = '{2'b00, {5'd0, 5'd0},  {8'h00, 8'h00}, 2'b00, {5'd0, 5'd0},  {5'd0, 5'd4},  {5'd0, 5'd0},  {8'h00, 8'h33}, {8'h00, 8'h00}, 2'b00, 2'b00};
        vecs[10] = '{2'b01, {5'd0, 5'd5},  {8'h00, 8'h44}, 2'b10, {5'd5, 5'd0},  {5'd5, 5'd0},  {5'd3, 5'd0},  {8'h44, 8'h00}, {8'h5A, 8'h00}, 2'b00, 2'b00};
        vecs[11] = '{2'b00, {5'd0, 5'd0},  {8'h00, 8'h00}, 2'b00, {5'd0, 5'd0},  {5'd5, 5'd0},  {5'd4, 5'd5},  {8'h44, 8'h00}, {8'h33, 8'h44}, 2'b10, 2'b01};

        // Reset: first edge brings state out of X, second cycle checks reset state
        reset = 1'b1;
        drive_idle();
        finish_cycle();
        settle();
        check("reset clear_busy", 32'(clear_busy), 32'd0);
        check("reset rdata1 regrd", 32'(rdata1_r), 32'd0);
        finish_cycle();
        reset = 1'b0;

        // Directed vectors, one per cycle
        for (int v = 0; v < 12; v++) begin
            drive_idle();
            we = vecs[v].we; rd = vecs[v].rd; wdata = vecs[v].wdata;
            rsv_en = vecs[v].rsv; rsv_addr = vecs[v].ra;
            rs1 = vecs[v].rs1; rs2 = vecs[v].rs2;
            settle();
            check($sformatf("vec%0d rdata1", v), 32'(rdata1), 32'(vecs[v].e1));
            check($sformatf("vec%0d rdata2", v), 32'(rdata2), 32'(vecs[v].e2));
            check($sformatf("vec%0d busy1", v), 32'(busy1), 32'(vecs[v].eb1));
            check($sformatf("vec%0d busy2", v), 32'(busy2), 32'(vecs[v].eb2));
            finish_cycle();
        end

        // Bulk clear: fill 1..31, pulse clear_req, time the sequence
        for (int a = 1; a < DEPTH; a++) begin
            drive_idle();
            we = 2'b01; rd = {5'd0, 5'(a)}; wdata = {8'h00, 8'(a) | 8'h40};
            if (a % 4 == 0) begin
                rsv_en = 2'b10; rsv_addr = {5'(a), 5'd0};
            end
            settle();
            finish_cycle();
        end
        drive_idle();
        clear_req = 1'b1;
        settle();
        finish_cycle();
        cnt = 0; done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            drive_idle();
            if (c == 5) begin
                we = 2'b01; rd = {5'd0, 5'd9}; wdata = {8'h00, 8'h77};
                rsv_en = 2'b01; rsv_addr = {5'd0, 5'd9}; clear_req = 1'b1;
            end
            settle();
            if (clear_busy !== 1'b1) done = 1'b1;
            else begin
                cnt++;
                finish_cycle();
            end
        end
        check("clear duration", 32'(cnt), 32'd31);
        finish_cycle();
        for (int a = 0; a < DEPTH; a++) begin
            drive_idle();
            rs1 = {5'(a), 5'(a)}; rs2 = {5'(a), 5'(a)};
            settle();
            check($sformatf("post-clear rdata1 r%0d", a), 32'(rdata1), 32'd0);
            check($sformatf("post-clear busy1 r%0d", a), 32'(busy1), 32'd0);
            finish_cycle();
        end

        // Reset in the 10th cycle of a clear aborts it
        for (int a = 20; a < 24; a++) begin
            drive_idle();
            we = 2'b10; rd = {5'(a), 5'd0}; wdata = {8'(a), 8'h00};
            settle();
            finish_cycle();
        end
        drive_idle();
        clear_req = 1'b1;
        settle();
        finish_cycle();
        for (int c = 0; c < 9; c++) begin
            drive_idle();
            settle();
            finish_cycle();
        end
        reset = 1'b1;
        drive_idle();
        settle();
        finish_cycle();
        reset = 1'b0;
        rs1 = {5'd21, 5'd20}; rs2 = {5'd23, 5'd22};
        settle();
        check("abort clear_busy", 32'(clear_busy), 32'd0);
        check("abort rdata1", 32'(rdata1), 32'd0);
        check("abort rdata2", 32'(rdata2), 32'd0);
        check("abort rdata1 regrd", 32'(rdata1_r), 32'd0);
        finish_cycle();

        // Registered read latency
        drive_idle();
        we = 2'b10; rd = {5'd12, 5'd0}; wdata = {8'h9C, 8'h00}; rs1 = {5'd0, 5'd12};
        settle();
        check("bypass comb r12", 32'(rdata1[7:0]), 32'h9C);
        finish_cycle();
        drive_idle();
        settle();
        check("regrd latency r12", 32'(rdata1_r[7:0]), 32'h9C);
        check("comb follows address", 32'(rdata1[7:0]), 32'h00);
        finish_cycle();
        drive_idle();
        settle();
        check("regrd follows r0", 32'(rdata1_r[7:0]), 32'h00);
        finish_cycle();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            drive_idle();
            reset     = ($urandom_range(0, 149) == 0);
            we        = 2'($urandom);
            rd        = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            wdata     = 16'($urandom);
            rsv_en    = 2'($urandom) & 2'($urandom);
            rsv_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            rs1       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            rs2       = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 7))};
            clear_req = ($urandom_range(0, 79) == 0);
            settle();
            finish_cycle();
        end
        reset = 1'b0;
        drive_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-lane register file; next generation of the 8-bit dual-lane register file.
- Each lane has two read ports and one write port.
- Adds write-through bypass across all lanes, deterministic write-conflict priority, optional registered reads, a per-register pending-write scoreboard, and a sequenced bulk-clear engine.
- Sits between decode/issue and writeback of the multi-issue datapath.

Parameters:
DATA_W, 8, register data width
ADDR_W, 5, register address width; depth = 2**ADDR_W entries
LANES, 2, number of issue lanes (each lane: 2 reads + 1 write + 1 reserve)
READ_REG, 0, 0 = combinational read (latency 0), 1 = registered read (latency 1)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
rs1  in  LANES*ADDR_W  read address A per lane (lane i at [i*ADDR_W +: ADDR_W])
rs2  in  LANES*ADDR_W  read address B per lane
rdata1  out  LANES*DATA_W  read data A per lane
rdata2  out  LANES*DATA_W  read data B per lane
we  in  LANES  write enable per lane
rd  in  LANES*ADDR_W  write address per lane
wdata  in  LANES*DATA_W  write data per lane
rsv_en  in  LANES  reserve request per lane (marks a destination as pending)
rsv_addr  in  LANES*ADDR_W  register to reserve
busy1  out  LANES  pending flag for rs1 of each lane
busy2  out  LANES  pending flag for rs2 of each lane
clear_req  in  1  pulse; starts a bulk clear
clear_busy  out  1  high while the clear sequence runs

Behaviour:
Storage and writes
- Storage holds 2**ADDR_W entries. Address 0 always reads 0; writes to address 0 are dropped.
- A lane write is active when we[i]=1 and rd[i]!=0. Storage updates at the rising edge.
- Two or more lanes writing the same rd in one cycle: the highest lane index wins; lower lanes are dropped for that address only.

Reads and bypass
- For each read address, if it matches any active write this cycle, the read returns that write's wdata (highest lane wins). Otherwise it returns storage. An address of 0 returns 0.
- READ_REG=0: rdata is combinational.
- READ_REG=1: rdata is registered, so the bypassed or stored value appears one cycle after the address.
- While reset=1: combinational rdata is forced to 0; registered rdata is loaded with 0.

Scoreboard
- One pending bit per entry.
- rsv_en[i] with rsv_addr[i]!=0 sets the bit at the edge. An active write to rd clears the bit at the edge.
- Set and clear of the same address in one cycle: set wins (a new producer was issued).
- busy1/busy2 = pending[rs], forced to 0 if an active write to that rs exists this cycle, and forced to 0 for address 0.
- busy flags are always combinational, regardless of READ_REG.

Clear engine
- FSM states: IDLE, CLEAR.
- IDLE -> CLEAR on clear_req=1; ptr <= 1.
- In CLEAR, each cycle: storage[ptr] <= 0, pending[ptr] <= 0, ptr <= ptr+1.
- At ptr == 2**ADDR_W-1, that entry is cleared and the FSM returns to IDLE. Duration is 2**ADDR_W-1 cycles (31 at default).
- clear_busy=1 exactly while in CLEAR.
- During CLEAR:
  - all lane writes and reserves are dropped;
  - rdata is forced to 0;
  - busy1/busy2 are forced to 1, so issue stalls;
  - clear_req is ignored.

Reset
- Synchronous. All entries = 0, all pending = 0, FSM = IDLE, ptr = 0, clear_busy = 0, registered rdata = 0.
- Reset asserted mid-clear aborts the clear; all state is still cleared by reset itself.
- Reset has priority over every other input in the same cycle.

Decomposition:
- Shared defines file regfile_defs.vh: FSM state encodings (ST_IDLE=1'b0, ST_CLEAR=1'b1) and default DATA_W/ADDR_W/LANES.
- Natural sub-module: regfile_scoreboard (pending bits, set/clear priority, busy lookup incl. address-0 and bypass masking, flush input driven by the clear engine).
- Storage, bypass, and the clear FSM stay in regfile_mp.

Test Plan:
- Write lane0 rd=3, wdata=0x5A; next cycle read rs1=3 on lane1 -> rdata1=0x5A. Same-cycle read of rs1=3 -> 0x5A via bypass (READ_REG=0).
- Lane0 and lane1 both write rd=7 (0x11, 0x22) in one cycle -> storage[7]=0x22; same-cycle bypass read of 7 -> 0x22.
- Write rd=0, wdata=0xFF -> read rs1=0 returns 0x00; rsv_en with rsv_addr=0 -> busy stays 0.
- rsv_en lane0 addr=4 -> next cycle busy1=1 for rs1=4. In the cycle lane1 writes rd=4, busy1=0 and rdata=wdata. The cycle after, pending[4]=0.
- Fill entries 1..31 with nonzero values, pulse clear_req -> clear_busy high for exactly 31 cycles, write to rd=9 mid-clear dropped; afterwards all reads return 0 and all busy=0.
- Assert reset at cycle 10 of a clear -> next cycle clear_busy=0 and all reads 0. READ_REG=1 build: data appears 1 cycle after the address; rdata=0 the cycle after reset.
